// File: rtl/lfsr_checker.sv
// lfsr_checker
// Purpose : receive-side checker for the 64-bit LFSR stimulus generator. It
//           self-synchronises to the incoming word stream, then flywheels its
//           own prediction and scores every following word against it.
// Latency : the word sampled at edge N is reflected in locked/err/counters
//           from cycle N+1. All outputs are registered.
// Backpressure: none. valid may toggle freely, and idle cycles freeze the
//           state, the prediction and the counters.
//
// Ports
//   clk           : clock, all logic on the rising edge
//   reset_n       : synchronous active-low reset
//   valid         : data holds a word to check this cycle
//   data[63:0]    : received word
//   clear         : zero the statistics counters (lock state is kept)
//   locked        : checker is in the LOCKED state
//   err           : one-cycle pulse for each mismatching word seen while LOCKED
//   word_count    : valid words checked while LOCKED (saturating)
//   err_count     : mismatching words while LOCKED (saturating)
//   bit_err_count : sum of popcount(data ^ expected) while LOCKED (saturating)

module lfsr_checker #(
  parameter int LOCK_CNT = 4,   // consecutive matches needed to lock (1..255)
  parameter int LOSS_CNT = 4,   // consecutive misses in LOCKED to drop lock (1..255)
  parameter int CNT_W    = 32   // width of the statistics counters
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid,
  input  logic [63:0]      data,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_err_count
);

  // The bit-error sum is formed at least one bit wider than both the counter
  // and the 7-bit popcount, so that clamping can detect overflow for any CNT_W.
  localparam int SUM_W = ((CNT_W > 7) ? CNT_W : 7) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Next value of the generator sequence. The XNOR feedback makes all-ones a
  // fixed point, so all-ones can never serve as a seed.
  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return {x[62:0], ~(x[19] ^ x[6] ^ x[2] ^ x[1])};
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [63:0]      exp_q;          // predicted value of the next valid word
  logic [7:0]       match_cnt_q;    // consecutive matches while in VERIFY
  logic [7:0]       miss_cnt_q;     // consecutive misses while in LOCKED
  logic             locked_q;
  logic             err_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] bit_cnt_q;

  // ---------------------------------------------------------------------------
  // Combinational helpers feeding the state update
  // ---------------------------------------------------------------------------
  logic             data_ones;
  logic             is_match;
  logic [63:0]      diff;
  logic [6:0]       pop;            // popcount(diff), 0..64
  logic [63:0]      exp_step;
  logic [63:0]      data_step;
  logic             match_hit;      // this match completes the lock run
  logic             miss_hit;       // this miss completes the loss run
  logic [CNT_W-1:0] word_cnt_d;
  logic [CNT_W-1:0] err_cnt_d;
  logic [CNT_W-1:0] bit_cnt_d;
  logic [SUM_W-1:0] bit_sum;

  always_comb begin
    data_ones = &data;
    is_match  = (data == exp_q);
    diff      = data ^ exp_q;
    exp_step  = lfsr_step(exp_q);
    data_step = lfsr_step(data);

    pop = '0;
    for (int i = 0; i < 64; i++) begin
      pop = pop + 7'(diff[i]);
    end

    // Run lengths compared one bit wider so LOCK_CNT/LOSS_CNT = 255 work.
    match_hit = (({1'b0, match_cnt_q} + 9'd1) == 9'(LOCK_CNT));
    miss_hit  = (({1'b0, miss_cnt_q}  + 9'd1) == 9'(LOSS_CNT));

    word_cnt_d = (word_cnt_q == CNT_MAX) ? CNT_MAX : word_cnt_q + 1'b1;
    err_cnt_d  = (err_cnt_q  == CNT_MAX) ? CNT_MAX : err_cnt_q  + 1'b1;

    // A single addend can carry the bit counter past its maximum in one step,
    // so clamp on the widened sum rather than testing for equality.
    bit_sum = SUM_W'(bit_cnt_q) + SUM_W'(pop);
    if (bit_sum > SUM_W'(CNT_MAX)) begin
      bit_cnt_d = CNT_MAX;
    end else begin
      bit_cnt_d = bit_sum[CNT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, prediction register and statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      exp_q       <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
      bit_cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;

      if (valid) begin
        unique case (state_q)
          ST_SEARCH: begin
            if (!data_ones) begin
              exp_q       <= data_step;
              match_cnt_q <= '0;
              state_q     <= ST_VERIFY;
            end
          end

          ST_VERIFY: begin
            if (is_match) begin
              exp_q       <= exp_step;
              match_cnt_q <= match_cnt_q + 8'd1;
              if (match_hit) begin
                state_q    <= ST_LOCKED;
                locked_q   <= 1'b1;
                miss_cnt_q <= '0;
              end
            end else begin
              // Candidate seed was wrong: restart the run from this word
              // unless it is the lock-up value.
              match_cnt_q <= '0;
              if (data_ones) begin
                state_q <= ST_SEARCH;
              end else begin
                exp_q <= data_step;
              end
            end
          end

          ST_LOCKED: begin
            // Flywheel: the prediction always advances on its own so that a
            // corrupted word never disturbs alignment.
            exp_q      <= exp_step;
            word_cnt_q <= word_cnt_d;
            if (is_match) begin
              miss_cnt_q <= '0;
            end else begin
              err_q      <= 1'b1;
              err_cnt_q  <= err_cnt_d;
              bit_cnt_q  <= bit_cnt_d;
              miss_cnt_q <= miss_cnt_q + 8'd1;
              if (miss_hit) begin
                state_q  <= ST_SEARCH;
                locked_q <= 1'b0;
              end
            end
          end

          default: begin
            state_q  <= ST_SEARCH;
            locked_q <= 1'b0;
          end
        endcase
      end

      // Clear overrides any increment taken above in the same cycle; err is
      // deliberately left alone.
      if (clear) begin
        word_cnt_q <= '0;
        err_cnt_q  <= '0;
        bit_cnt_q  <= '0;
      end
    end
  end

  assign locked        = locked_q;
  assign err           = err_q;
  assign word_count    = word_cnt_q;
  assign err_count     = err_cnt_q;
  assign bit_err_count = bit_cnt_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker
// Purpose : drives two checker instances (default build, and a 4-bit-counter
//           build that practically never loses lock) with the same stream and
//           compares every output against a reference model every cycle.
// Stimulus: directed scenarios first, then a long randomized stream.

module tb_lfsr_checker;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        reset_n;
  logic        valid;
  logic [63:0] data;
  logic        clear;

  logic        lk0, er0, lk1, er1;
  logic [31:0] wc0, ec0, bc0;
  logic [3:0]  wc1, ec1, bc1;

  int n_checks = 0;
  int n_errors = 0;

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(4), .CNT_W(32)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear(clear),
    .locked(lk0), .err(er0), .word_count(wc0), .err_count(ec0),
    .bit_err_count(bc0)
  );

  lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(255), .CNT_W(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .data(data), .clear(clear),
    .locked(lk1), .err(er1), .word_count(wc1), .err_count(ec1),
    .bit_err_count(bc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: lock acquisition and loss described as run lengths, with
  // statistics kept as unbounded totals and clamped to the counter width only
  // when compared.
  // ---------------------------------------------------------------------------
  int              m_mode  [2];   // 0 searching, 1 verifying a seed, 2 locked
  logic [63:0]     m_exp   [2];
  int              m_run   [2];
  int              m_miss  [2];
  longint unsigned m_words [2];
  longint unsigned m_errs  [2];
  longint unsigned m_bits  [2];
  bit              m_err   [2];

  function automatic int lock_of(input int k); return 4; endfunction
  function automatic int loss_of(input int k); return (k == 0) ? 4 : 255; endfunction
  function automatic int width_of(input int k); return (k == 0) ? 32 : 4; endfunction

  function automatic logic [63:0] nxt(input logic [63:0] x);
    logic fb;
    fb = ~(x[19] ^ x[6] ^ x[2] ^ x[1]);
    return (x << 1) | {63'd0, fb};
  endfunction

  function automatic logic [63:0] sat(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clock(input int k, input bit rst, input bit v,
                             input logic [63:0] d, input bit c);
    if (rst) begin
      m_mode[k] = 0; m_exp[k] = '0; m_run[k] = 0; m_miss[k] = 0;
      m_words[k] = 0; m_errs[k] = 0; m_bits[k] = 0; m_err[k] = 0;
      return;
    end
    m_err[k] = 0;
    if (v) begin
      if (m_mode[k] == 0) begin
        if (d != ONES) begin
          m_exp[k] = nxt(d); m_run[k] = 0; m_mode[k] = 1;
        end
      end else if (m_mode[k] == 1) begin
        if (d == m_exp[k]) begin
          m_exp[k] = nxt(m_exp[k]);
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == lock_of(k)) begin
            m_mode[k] = 2; m_miss[k] = 0;
          end
        end else begin
          m_run[k] = 0;
          if (d == ONES) m_mode[k] = 0;
          else           m_exp[k] = nxt(d);
        end
      end else begin
        m_words[k] = m_words[k] + 1;
        if (d != m_exp[k]) begin
          m_err[k]  = 1;
          m_errs[k] = m_errs[k] + 1;
          m_bits[k] = m_bits[k] + longint'($countones(d ^ m_exp[k]));
          m_miss[k] = m_miss[k] + 1;
          if (m_miss[k] == loss_of(k)) m_mode[k] = 0;
        end else begin
          m_miss[k] = 0;
        end
        m_exp[k] = nxt(m_exp[k]);
      end
    end
    if (c) begin
      m_words[k] = 0; m_errs[k] = 0; m_bits[k] = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic        o_lk, o_er;
      logic [63:0] o_wc, o_ec, o_bc;
      o_lk = (k == 0) ? lk0 : lk1;
      o_er = (k == 0) ? er0 : er1;
      o_wc = (k == 0) ? 64'(wc0) : 64'(wc1);
      o_ec = (k == 0) ? 64'(ec0) : 64'(ec1);
      o_bc = (k == 0) ? 64'(bc0) : 64'(bc1);
      check($sformatf("u%0d_locked", k), 64'(o_lk), 64'(m_mode[k] == 2));
      check($sformatf("u%0d_err", k), 64'(o_er), 64'(m_err[k]));
      check($sformatf("u%0d_word_count", k), o_wc, sat(m_words[k], width_of(k)));
      check($sformatf("u%0d_err_count", k), o_ec, sat(m_errs[k], width_of(k)));
      check($sformatf("u%0d_bit_err_count", k), o_bc, sat(m_bits[k], width_of(k)));
    end
  endtask

  // One clock: inputs applied away from the edge, model advanced at the edge,
  // outputs sampled 1 time unit after the edge.
  task automatic cyc(input bit v, input logic [63:0] d, input bit c, input bit r);
    valid   = v;
    data    = d;
    clear   = c;
    reset_n = !r;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_clock(k, r, v, d, c);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic word(input logic [63:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic acquire();
    word(64'h0); word(64'h1); word(64'h3); word(64'h6); word(64'hD);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] g;
    logic [63:0] d;
    bit          v, c, r;
    int          burst;
    int          roll;

    reset_n = 1'b0; valid = 1'b0; data = '0; clear = 1'b0;
    @(negedge clk);

    // Reset state
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    check("rst_locked", 64'(lk0), 64'd0);
    check("rst_word_count", 64'(wc0), 64'd0);

    // Acquire lock on 0, 1, 3, 6, 0xD
    acquire();
    check("acq_locked", 64'(lk0), 64'd1);
    check("acq_word_count", 64'(wc0), 64'd0);

    // Single-word two-bit error, then the flywheel word still matches
    word(64'h1A ^ 64'h5);
    check("biterr_err", 64'(er0), 64'd1);
    check("biterr_err_count", 64'(ec0), 64'd1);
    check("biterr_bit_count", 64'(bc0), 64'd2);
    word(64'h34);
    check("flywheel_err", 64'(er0), 64'd0);
    check("flywheel_word_count", 64'(wc0), 64'd2);
    check("flywheel_locked", 64'(lk0), 64'd1);

    // Loss of lock after four consecutive misses
    cyc(1'b0, 64'd0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      word(64'h0);
      check("loss_err_pulse", 64'(er0), 64'd1);
    end
    check("loss_err_count", 64'(ec0), 64'd4);
    check("loss_unlocked", 64'(lk0), 64'd0);
    idle(1);
    acquire();
    check("reacq_locked", 64'(lk0), 64'd1);

    // Lock-up seed ignored, idle gaps do not advance the prediction
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) word(ONES);
    check("lockup_unlocked", 64'(lk0), 64'd0);
    word(64'h0); idle(5); word(64'h1); idle(1);
    word(64'h3); word(64'h6); word(64'hD);
    check("gap_locked", 64'(lk0), 64'd1);

    // Clear together with a mismatching word
    word(64'h1A); word(64'h34);
    cyc(1'b1, 64'h69, 1'b1, 1'b0);
    check("clear_err", 64'(er0), 64'd1);
    check("clear_err_count", 64'(ec0), 64'd0);
    check("clear_bit_count", 64'(bc0), 64'd0);
    check("clear_word_count", 64'(wc0), 64'd0);
    check("clear_locked", 64'(lk0), 64'd1);

    // Saturation of the 4-bit counters
    for (int i = 0; i < 20; i++) word(64'h0);
    check("sat_err_count", 64'(ec1), 64'd15);
    check("sat_bit_count", 64'(bc1), 64'd15);
    check("sat_locked", 64'(lk1), 64'd1);

    // Randomized stream from a software generator with injected faults
    cyc(1'b0, 64'd0, 1'b0, 1'b1);
    g = 64'd0;
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(3, 0) != 0);
      c = ($urandom_range(49, 0) == 0);
      r = ($urandom_range(499, 0) == 0);
      d = {$urandom, $urandom};
      if (v) begin
        roll = $urandom_range(99, 0);
        if (burst > 0) begin
          d = g ^ (64'd1 << $urandom_range(63, 0));
          burst--;
        end else if (roll < 80) begin
          d = g;
        end else if (roll < 88) begin
          d = g ^ {32'd0, $urandom} ^ 64'd1;
          if (d == g) d = g ^ 64'h2;
        end else if (roll < 91) begin
          d = ONES;
        end else if (roll < 94) begin
          burst = $urandom_range(6, 3);
          d = g ^ 64'h8000_0000_0000_0000;
        end else if (roll < 97) begin
          g = {$urandom, $urandom} & 64'h7FFF_FFFF_FFFF_FFFF;
          d = g;
        end
        g = nxt(g);
      end
      cyc(v, d, c, r);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
